// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and helpers for the APB round-robin arbiter.
// Optional watchdog is enabled with the APB_ARB_TIMEOUT_EN macro.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } arb_state_e;

  localparam int PROT_WIDTH = 3;

  // Upper bounds for the flattened-vector slicer below.
  localparam int SLICE_MAX_FLAT = 4096;
  localparam int SLICE_MAX_W    = 128;

  // Returns slice idx (each 'width' bits wide) of a zero-extended flattened vector.
  function automatic logic [SLICE_MAX_W-1:0] get_slice(
    input logic [SLICE_MAX_FLAT-1:0] flat,
    input int                        idx,
    input int                        width
  );
    logic [SLICE_MAX_FLAT-1:0] shifted;
    logic [SLICE_MAX_W-1:0]    mask;
    shifted = flat >> (idx * width);
    mask    = ~({SLICE_MAX_W{1'b1}} << width);
    return shifted[SLICE_MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Bridge-facing bundle: command outputs toward the APB bridge plus the APB bus taps.
// Shared by apb_rr_arbiter (master side) and the bridge/environment (slave side).
interface apb_rr_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int SLAVES_NUM   = 2
);

  logic                    xfer_o;
  logic [ADDR_WIDTH-1:0]   addr_o;
  logic [DATA_WIDTH-1:0]   wdata_o;
  logic                    write_o;
  logic [STROBE_WIDTH-1:0] strb_o;
  logic [PROT_WIDTH-1:0]   prot_o;
  logic [SLAVES_NUM-1:0]   sel_o;

  logic                    PENABLE;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    output xfer_o, addr_o, wdata_o, write_o, strb_o, prot_o, sel_o,
    input  PENABLE, PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  xfer_o, addr_o, wdata_o, write_o, strb_o, prot_o, sel_o,
    output PENABLE, PREADY, PSLVERR, PRDATA
  );

endinterface

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the pointer, wrapping.
// The pointer register lives in the parent.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               any_req_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin front-end sharing one APB bridge among NUM_REQ requesters, one transaction at a time.
// Define APB_ARB_TIMEOUT_EN to add the BUSY watchdog and the timeout_o port.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STROBE_WIDTH = 4,
  parameter int SLAVES_NUM   = 2
`ifdef APB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*STROBE_WIDTH-1:0] req_strb_i,
  input  logic [NUM_REQ*PROT_WIDTH-1:0]   req_prot_i,
  input  logic [NUM_REQ*SLAVES_NUM-1:0]   req_sel_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            slverr_o,
`ifdef APB_ARB_TIMEOUT_EN
  output logic                            timeout_o,
`endif
  apb_rr_arbiter_if.master                bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0]        ptr_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic [STROBE_WIDTH-1:0] strb_q;
  logic [PROT_WIDTH-1:0]   prot_q;
  logic [SLAVES_NUM-1:0]   sel_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    slverr_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic               any_req;
  logic [IDX_W-1:0]   win_idx;
  logic               busy;
  logic               cmpl;
  logic               tmo_hit;
  logic               xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .gnt_o     (pick_gnt),
    .any_req_o (any_req)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) win_idx = IDX_W'(i);
    end
  end

  // The bridge leaves ACCESS on PSLVERR even without PREADY, so either ends the transfer.
  assign busy = (state_q == ST_BUSY);
  assign cmpl = bus.PENABLE && (bus.PREADY || bus.PSLVERR);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             timeout_q;

  // Counter is held at zero outside BUSY, so it restarts on every BUSY entry.
  assign tmo_hit = busy && !cmpl && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= busy ? tmo_cnt_q + CNT_W'(1) : '0;
      timeout_q <= tmo_hit;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req)         state_d = ST_BUSY;
      ST_BUSY: if (cmpl || tmo_hit) state_d = ST_DONE;
      ST_DONE:                      state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Outputs: Transfer drops in the completion cycle so the bridge does not reissue.
  always_comb begin
    xfer   = busy && !cmpl && !tmo_hit;
    done_o = (state_q == ST_DONE) ? gnt_q : '0;
  end

  // Command capture on grant, response capture on completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      prot_q   <= '0;
      sel_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q   <= pick_gnt;
            ptr_q   <= win_idx;
            addr_q  <= ADDR_WIDTH'(get_slice(SLICE_MAX_FLAT'(req_addr_i), int'(win_idx), ADDR_WIDTH));
            wdata_q <= DATA_WIDTH'(get_slice(SLICE_MAX_FLAT'(req_wdata_i), int'(win_idx), DATA_WIDTH));
            write_q <= req_write_i[win_idx];
            strb_q  <= STROBE_WIDTH'(get_slice(SLICE_MAX_FLAT'(req_strb_i), int'(win_idx), STROBE_WIDTH));
            prot_q  <= PROT_WIDTH'(get_slice(SLICE_MAX_FLAT'(req_prot_i), int'(win_idx), PROT_WIDTH));
            sel_q   <= SLAVES_NUM'(get_slice(SLICE_MAX_FLAT'(req_sel_i), int'(win_idx), SLAVES_NUM));
          end
        end
        ST_BUSY: begin
          if (cmpl) begin
            rdata_q  <= write_q ? '0 : bus.PRDATA;
            slverr_q <= bus.PSLVERR;
          end else if (tmo_hit) begin
            rdata_q  <= '0;
            slverr_q <= 1'b1;
          end
        end
        ST_DONE: gnt_q <= '0;
        default: gnt_q <= '0;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign rdata_o     = rdata_q;
  assign slverr_o    = slverr_q;
  assign bus.xfer_o  = xfer;
  assign bus.addr_o  = addr_q;
  assign bus.wdata_o = wdata_q;
  assign bus.write_o = write_q;
  assign bus.strb_o  = strb_q;
  assign bus.prot_o  = prot_q;
  assign bus.sel_o   = sel_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Scoreboard bench for apb_rr_arbiter with a small APB bridge/slave model on the bus taps.
// Define APB_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_apb_rr_arbiter;
  import apb_arb_pkg::*;

  localparam int NR  = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = 4;
  localparam int SN  = 2;
  localparam int CW  = 128;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0] req;
  logic [AW-1:0] r_addr  [NR];
  logic [DW-1:0] r_wdata [NR];
  logic          r_write [NR];
  logic [SW-1:0] r_strb  [NR];
  logic [2:0]    r_prot  [NR];
  logic [SN-1:0] r_sel   [NR];

  logic [NR*AW-1:0] req_addr_flat;
  logic [NR*DW-1:0] req_wdata_flat;
  logic [NR-1:0]    req_write_vec;
  logic [NR*SW-1:0] req_strb_flat;
  logic [NR*3-1:0]  req_prot_flat;
  logic [NR*SN-1:0] req_sel_flat;

  assign req_addr_flat  = {r_addr[1],  r_addr[0]};
  assign req_wdata_flat = {r_wdata[1], r_wdata[0]};
  assign req_write_vec  = {r_write[1], r_write[0]};
  assign req_strb_flat  = {r_strb[1],  r_strb[0]};
  assign req_prot_flat  = {r_prot[1],  r_prot[0]};
  assign req_sel_flat   = {r_sel[1],   r_sel[0]};

  logic [NR-1:0] gnt;
  logic [NR-1:0] done;
  logic [DW-1:0] rdata;
  logic          slverr;
`ifdef APB_ARB_TIMEOUT_EN
  logic          tmo;
`endif

  apb_rr_arbiter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STROBE_WIDTH(SW), .SLAVES_NUM(SN)
  ) bus ();

  apb_rr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STROBE_WIDTH(SW), .SLAVES_NUM(SN)
`ifdef APB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .PCLK        (clk),
    .PRESETn     (rst_n),
    .req_i       (req),
    .req_addr_i  (req_addr_flat),
    .req_wdata_i (req_wdata_flat),
    .req_write_i (req_write_vec),
    .req_strb_i  (req_strb_flat),
    .req_prot_i  (req_prot_flat),
    .req_sel_i   (req_sel_flat),
    .gnt_o       (gnt),
    .done_o      (done),
    .rdata_o     (rdata),
    .slverr_o    (slverr),
`ifdef APB_ARB_TIMEOUT_EN
    .timeout_o   (tmo),
`endif
    .bus         (bus)
  );

  // Slave behaviour knobs.
  int          waits    = 0;
  logic        hang     = 1'b0;
  logic        err_mode = 1'b0;
  logic [DW-1:0] rd_base = '0;

  // Bridge + slave model: IDLE -> SETUP -> ACCESS (wait states) -> IDLE/SETUP.
  typedef enum logic [1:0] {B_IDLE, B_SETUP, B_ACCESS} bst_e;
  bst_e          bst;
  int            wcnt;
  logic [AW-1:0] paddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst         <= B_IDLE;
      wcnt        <= 0;
      paddr       <= '0;
      bus.PENABLE <= 1'b0;
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      bus.PRDATA  <= '0;
    end else begin
      case (bst)
        B_IDLE: if (bus.xfer_o) begin
          bst   <= B_SETUP;
          paddr <= bus.addr_o;
        end
        B_SETUP: begin
          bst         <= B_ACCESS;
          wcnt        <= 0;
          bus.PENABLE <= 1'b1;
          bus.PREADY  <= !hang && !err_mode && (waits == 0);
          bus.PSLVERR <= !hang && err_mode && (waits == 0);
          bus.PRDATA  <= rd_base ^ paddr;
        end
        default: begin
          if (bus.PREADY || bus.PSLVERR) begin
            bus.PENABLE <= 1'b0;
            bus.PREADY  <= 1'b0;
            bus.PSLVERR <= 1'b0;
            if (bus.xfer_o) begin
              bst   <= B_SETUP;
              paddr <= bus.addr_o;
            end else begin
              bst <= B_IDLE;
            end
          end else begin
            wcnt        <= wcnt + 1;
            bus.PREADY  <= !hang && !err_mode && (wcnt + 1 >= waits);
            bus.PSLVERR <= !hang && err_mode && (wcnt + 1 >= waits);
          end
        end
      endcase
    end
  end

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          write;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    logic [SN-1:0] sel;
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          tmo;
  } exp_t;

  exp_t sb[$];
  int   n_total  = 0;
  int   n_bad    = 0;
  int   done_cnt = 0;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input int k, input logic timed_out);
    exp_t e;
    e.gnt    = NR'(1) << k;
    e.addr   = r_addr[k];
    e.wdata  = r_wdata[k];
    e.write  = r_write[k];
    e.strb   = r_strb[k];
    e.prot   = r_prot[k];
    e.sel    = r_sel[k];
    e.rdata  = r_write[k] ? '0 : (rd_base ^ r_addr[k]);
    e.slverr = err_mode;
    e.tmo    = timed_out;
    if (timed_out) begin
      e.rdata  = '0;
      e.slverr = 1'b1;
    end
    return e;
  endfunction

  // Monitor: checks the command at grant, its stability through BUSY, and the response at done_o.
  logic [NR-1:0] prev_gnt;
  logic          cmpl_prev;
  int            busy_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt  = '0;
      cmpl_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if ((|gnt) && !(|prev_gnt)) begin
        busy_len = 0;
        if (sb.size() == 0) check("sb_underflow_gnt", CW'(gnt), CW'(0));
        else begin
          check("gnt",   CW'(gnt),         CW'(sb[0].gnt));
          check("addr",  CW'(bus.addr_o),  CW'(sb[0].addr));
          check("wdata", CW'(bus.wdata_o), CW'(sb[0].wdata));
          check("write", CW'(bus.write_o), CW'(sb[0].write));
          check("strb",  CW'(bus.strb_o),  CW'(sb[0].strb));
          check("prot",  CW'(bus.prot_o),  CW'(sb[0].prot));
          check("sel",   CW'(bus.sel_o),   CW'(sb[0].sel));
        end
      end
      if ((|gnt) && !(|done)) begin
        busy_len++;
        if (sb.size() != 0)
          check("cmd_hold",
                CW'({bus.addr_o, bus.wdata_o, bus.write_o, bus.strb_o, bus.prot_o, bus.sel_o}),
                CW'({sb[0].addr, sb[0].wdata, sb[0].write, sb[0].strb, sb[0].prot, sb[0].sel}));
        if (bus.PENABLE && (bus.PREADY || bus.PSLVERR))
          check("xfer_low_in_cmpl", CW'(bus.xfer_o), CW'(0));
      end
      if (|done) begin
        if (sb.size() == 0) check("sb_underflow_done", CW'(done), CW'(0));
        else begin
          exp_t e;
          e = sb.pop_front();
          check("done",        CW'(done),      CW'(e.gnt));
          check("gnt_at_done", CW'(gnt),       CW'(e.gnt));
          check("rdata",       CW'(rdata),     CW'(e.rdata));
          check("slverr",      CW'(slverr),    CW'(e.slverr));
          check("done_lat",    CW'(cmpl_prev), CW'(!e.tmo));
`ifdef APB_ARB_TIMEOUT_EN
          check("timeout_o",   CW'(tmo),       CW'(e.tmo));
          if (e.tmo) check("busy_cycles", CW'(busy_len), CW'(TMO));
`endif
        end
        done_cnt++;
      end
      cmpl_prev = (|gnt) && !(|done) && bus.PENABLE && (bus.PREADY || bus.PSLVERR);
      prev_gnt  = gnt;
    end
  end

  task automatic wait_dones(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_count", CW'(done_cnt), CW'(target));
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic [SW-1:0] s, input logic [2:0] p,
                         input logic [SN-1:0] sl);
    r_addr[k] = a; r_wdata[k] = d; r_write[k] = w;
    r_strb[k] = s; r_prot[k]  = p; r_sel[k]   = sl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    for (int k = 0; k < NR; k++) set_req(k, '0, '0, 1'b0, '0, '0, '0);

    repeat (3) @(negedge clk);
    check("rst_gnt",    CW'(gnt),        CW'(0));
    check("rst_done",   CW'(done),       CW'(0));
    check("rst_xfer",   CW'(bus.xfer_o), CW'(0));
    check("rst_addr",   CW'(bus.addr_o), CW'(0));
    check("rst_rdata",  CW'(rdata),      CW'(0));
    check("rst_slverr", CW'(slverr),     CW'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read, requester 0, zero wait states.
    set_req(0, 32'h10, 32'h0, 1'b0, 4'h0, 3'b000, 2'b01);
    rd_base = 32'hA5A5_0011;
    waits   = 0;
    sb.push_back(mk_exp(0, 1'b0));
    req = 2'b01;
    wait_dones(1, 50);
    req = '0;
    repeat (4) @(negedge clk);
    check("rdata_hold",  CW'(rdata),  CW'(32'hA5A5_0001));
    check("slverr_hold", CW'(slverr), CW'(0));

    // Write from requester 1 with three wait states.
    set_req(1, 32'h24, 32'hDEAD_BEEF, 1'b1, 4'hF, 3'b010, 2'b10);
    waits = 3;
    sb.push_back(mk_exp(1, 1'b0));
    req = 2'b10;
    wait_dones(2, 50);
    req = '0;
    repeat (2) @(negedge clk);

    // Both requesting: expect 0,1,0,1.
    set_req(0, 32'h100, 32'h0, 1'b0, 4'h0, 3'b000, 2'b01);
    set_req(1, 32'h204, 32'h0, 1'b0, 4'h0, 3'b001, 2'b10);
    rd_base = 32'h1234_0000;
    waits   = 1;
    for (int t = 0; t < 4; t++) sb.push_back(mk_exp(t % 2, 1'b0));
    req = 2'b11;
    wait_dones(6, 200);
    req = '0;
    repeat (2) @(negedge clk);

    // PSLVERR without PREADY, then a normal read.
    set_req(0, 32'h30, 32'h0, 1'b0, 4'h0, 3'b000, 2'b01);
    err_mode = 1'b1;
    waits    = 2;
    sb.push_back(mk_exp(0, 1'b0));
    req = 2'b01;
    wait_dones(7, 50);
    req = '0;
    err_mode = 1'b0;
    waits    = 0;
    set_req(0, 32'h34, 32'h0, 1'b0, 4'h0, 3'b000, 2'b01);
    sb.push_back(mk_exp(0, 1'b0));
    req = 2'b01;
    wait_dones(8, 50);
    req = '0;
    repeat (2) @(negedge clk);

    // Reset during BUSY against a stalled slave.
    hang = 1'b1;
    set_req(0, 32'h40, 32'h0, 1'b0, 4'h0, 3'b000, 2'b01);
    sb.push_back(mk_exp(0, 1'b0));
    req = 2'b01;
    for (int i = 0; i < 20 && !bus.xfer_o; i++) @(negedge clk);
    check("xfer_rise", CW'(bus.xfer_o), CW'(1));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt",    CW'(gnt),        CW'(0));
    check("arst_done",   CW'(done),       CW'(0));
    check("arst_xfer",   CW'(bus.xfer_o), CW'(0));
    check("arst_addr",   CW'(bus.addr_o), CW'(0));
    check("arst_rdata",  CW'(rdata),      CW'(0));
    check("arst_slverr", CW'(slverr),     CW'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    check("arst_no_done", CW'(done), CW'(0));
    hang = 1'b0;
    set_req(1, 32'h44, 32'h5555, 1'b1, 4'h3, 3'b000, 2'b10);
    sb.push_back(mk_exp(0, 1'b0));
    sb.push_back(mk_exp(1, 1'b0));
    req = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    wait_dones(10, 100);
    req = '0;
    repeat (2) @(negedge clk);

`ifdef APB_ARB_TIMEOUT_EN
    // Slave never responds: watchdog forces completion.
    hang = 1'b1;
    set_req(0, 32'h50, 32'h0, 1'b0, 4'h0, 3'b000, 2'b01);
    sb.push_back(mk_exp(0, 1'b1));
    req = 2'b01;
    wait_dones(11, 60);
    req  = '0;
    hang = 1'b0;
    repeat (5) @(negedge clk);
    set_req(0, 32'h54, 32'h0, 1'b0, 4'h0, 3'b000, 2'b01);
    sb.push_back(mk_exp(0, 1'b0));
    req = 2'b01;
    wait_dones(12, 50);
    req = '0;
    repeat (2) @(negedge clk);
`endif

    check("sb_empty", CW'(sb.size()), CW'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Round-robin front-end that shares the single APB master bridge (apb_bus) between NUM_REQ requesters (CPU, DMA, debug).
- Sequences one whole APB transaction at a time: registers the winner's command, drives the bridge's Transfer/command inputs, watches the APB bus for completion, then returns read data and error to that requester.
- Sits between the requesters and the bridge; it taps PENABLE/PREADY/PSLVERR/PRDATA directly from the APB bus.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- DATA_WIDTH, 32, data width.
- ADDR_WIDTH, 32, address width.
- STROBE_WIDTH, 4, write strobe width.
- SLAVES_NUM, 2, PSEL vector width.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with APB_ARB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous reset, active-low.
- req_i  in  NUM_REQ  per-requester level request; held until done_o bit.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i belongs to requester i.
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_write_i  in  NUM_REQ  1 = write.
- req_strb_i  in  NUM_REQ*STROBE_WIDTH  flattened strobes.
- req_prot_i  in  NUM_REQ*3  flattened protection.
- req_sel_i  in  NUM_REQ*SLAVES_NUM  flattened one-hot slave selects.
- gnt_o  out  NUM_REQ  one-hot owner; held for the whole transaction.
- done_o  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rdata_o  out  DATA_WIDTH  read data; valid while done_o is nonzero.
- slverr_o  out  1  error flag; valid while done_o is nonzero.
- xfer_o  out  1  drives bridge Transfer.
- addr_o  out  ADDR_WIDTH  drives bridge ADDR_in.
- wdata_o  out  DATA_WIDTH  drives bridge DATA_in.
- write_o  out  1  drives bridge WRITE_in.
- strb_o  out  STROBE_WIDTH  drives bridge STROB_in.
- prot_o  out  3  drives bridge PROT_in.
- sel_o  out  SLAVES_NUM  drives bridge SEL_in.
- PENABLE  in  1  APB bus tap.
- PREADY  in  1  APB bus tap.
- PSLVERR  in  1  APB bus tap.
- PRDATA  in  DATA_WIDTH  APB bus tap.

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any req_i bit is set, pick the winner: first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - At the next edge: register the winner's addr/wdata/write/strb/prot/sel into the *_o registers, set gnt_o, set pointer = winner, go to BUSY.
- BUSY:
  - cmpl = PENABLE && (PREADY || PSLVERR). This matches the bridge, which leaves ACCESS on PSLVERR even without PREADY.
  - xfer_o is combinational: (state==BUSY) && !cmpl. It must drop in the completion cycle so the bridge returns to IDLE and does not reissue.
  - Command outputs stay frozen throughout BUSY.
  - On cmpl: capture PRDATA (reads only; writes return 0) and PSLVERR; go to DONE.
- DONE (1 cycle):
  - done_o = gnt_o; rdata_o and slverr_o valid.
  - Next edge: gnt_o and done_o go to 0, state returns to IDLE.
  - rdata_o and slverr_o hold their values until the next DONE.
- Latency: request in IDLE → xfer_o high 1 cycle later → bridge SETUP → ACCESS → completion. done_o pulses the cycle after cmpl. There are at least 2 idle cycles between transactions (DONE, then IDLE arbitration).
- Simultaneous requests: round-robin. With NUM_REQ=2 and both requesting permanently, grants alternate 0,1,0,1.
- A requester dropping req_i while granted: ignored; the transaction completes and done_o still pulses.
- req_i changing during BUSY: does not affect the current transaction; it is evaluated at the next IDLE.
- Reset mid-transaction: immediate return to reset values, with no done_o pulse.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no cmpl: xfer_o drops, the transaction is forced to DONE with slverr_o=1 and rdata_o=0, and a new output timeout_o (1 bit) pulses together with done_o.
  - The bridge may remain in ACCESS until the slave responds; its late completion is ignored because the arbiter is no longer in BUSY.
- Undefined: no counter and no timeout_o port; BUSY waits indefinitely.

Decomposition:
- Package apb_arb_pkg:
  - state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - PROT_WIDTH=3.
  - a helper function that returns slice i of a flattened vector.
- Sub-module rr_pick:
  - combinational round-robin winner (req vector + pointer → one-hot grant + any_req).
  - instantiated once; the parent holds the pointer register.

Test Plan:
- Single read, requester 0 (addr 0x10, sel 01); slave PREADY on the first ACCESS cycle with PRDATA=0xA5A5_0001 → done_o=01 one cycle later, rdata_o=0xA5A5_0001, slverr_o=0, xfer_o low in the completion cycle.
- Write from requester 1 (addr 0x24, wdata 0xDEAD_BEEF, strb 0xF); slave inserts 3 wait states → addr_o/wdata_o stable across all BUSY cycles; done_o=10; rdata_o=0.
- Both req_i=11 held for 4 transactions → gnt_o sequence 01,10,01,10; each grant sees exactly one done_o.
- PSLVERR=1 with PREADY=0 during ACCESS → completion taken; slverr_o=1; done_o pulses; the next transaction proceeds normally.
- PRESETn pulsed low during BUSY → all outputs 0 asynchronously; no done_o; after release, a pending requester 0 wins first.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never ready → timeout_o and done_o pulse after 8 BUSY cycles, slverr_o=1.
